fbreader: RTL

- PLB master-read engine that scans one framebuffer frame out of external memory, word by word.
- Pushes each 32-bit pixel word into a display-side FIFO.
- Read-direction counterpart of the framebuffer write path: the writer drains the pixel FIFO onto the bus; this block fills a scan-out FIFO from the bus for the video output stage.
- One frame per start pulse.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/fbreader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer constants and reader FSM state encoding
//
// Purpose: frame geometry shared by the framebuffer read and write paths,
//          default reader parameters, and the reader state encoding.
// Ports:   none (package).

package fb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        PUSH = 2'd3
    } fb_state_e;

    localparam int unsigned FB_H_PIXELS    = 640;
    localparam int unsigned FB_V_LINES     = 480;
    localparam int unsigned FB_BPP         = 32;
    localparam int unsigned FB_WORD_COUNT  = FB_H_PIXELS * FB_V_LINES;
    localparam int unsigned FB_ADDR_STRIDE = FB_BPP / 8;
    localparam int unsigned FB_CNT_W       = 19;

endpackage

// File: rtl/fbreader.sv
// rtl/fbreader.sv - PLB master-read engine scanning one frame into a FIFO
//
// Purpose: on a start pulse, reads WORD_COUNT consecutive 32-bit words from
//          base_addr upward with single-beat PLB reads, one outstanding at a
//          time, and pushes each word into the display-side FIFO.
// Ports:
//   PLB_clk, reset_n         clock, asynchronous active-low reset
//   start, base_addr         frame request and frame base byte address
//   busy, frame_done         frame in progress / end-of-frame pulse
//   bus_error                sticky, set by any errored read in the frame
//   IP2Bus_MstRd_Req/_Addr   read request and byte address to the bus
//   Bus2IP_Mst_*             command ack, completion, error, read data
//   fifo_data/_wr_en/_full   scan-out FIFO write side

module fbreader
    import fb_pkg::*;
#(
    parameter int unsigned WORD_COUNT  = FB_WORD_COUNT,
    parameter int unsigned CNT_W       = FB_CNT_W,
    parameter int unsigned ADDR_STRIDE = FB_ADDR_STRIDE
) (
    input  logic        PLB_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        frame_done,
    output logic        bus_error,
    output logic        IP2Bus_MstRd_Req,
    output logic [31:0] IP2Bus_Mst_Addr,
    input  logic        Bus2IP_Mst_CmdAck,
    input  logic        Bus2IP_Mst_Cmplt,
    input  logic        Bus2IP_Mst_Error,
    input  logic [31:0] Bus2IP_MstRd_d,
    output logic [31:0] fifo_data,
    output logic        fifo_wr_en,
    input  logic        fifo_full
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_COUNT - 1);
    localparam logic [31:0]      STRIDE   = 32'(ADDR_STRIDE);

    fb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  index_q, index_d;
    logic [31:0]       addr_q,  addr_d;
    logic [31:0]       data_q,  data_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;

    always_ff @(posedge PLB_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            index_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        // An errored read still yields a (zero) pixel so the frame keeps its
        // geometry; the fault is only reported through the sticky flag.
        if ((state_q == WAIT && Bus2IP_Mst_Cmplt) ||
            (state_q == REQ && Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt)) begin
            if (Bus2IP_Mst_Error) begin
                data_d = 32'h0;
                err_d  = 1'b1;
            end else begin
                data_d = Bus2IP_MstRd_d;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    index_d = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (Bus2IP_Mst_CmdAck) begin
                    state_d = Bus2IP_Mst_Cmplt ? PUSH : WAIT;
                end
            end
            WAIT: begin
                if (Bus2IP_Mst_Cmplt) begin
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (!fifo_full) begin
                    if (index_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + 1'b1;
                        addr_d  = addr_q + STRIDE;
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign IP2Bus_MstRd_Req = (state_q == REQ);
    assign IP2Bus_Mst_Addr  = addr_q;
    // The write strobe follows fifo_full in the same cycle so a word is never
    // written into a full FIFO and is written the first cycle space appears.
    assign fifo_wr_en       = (state_q == PUSH) && !fifo_full;
    assign fifo_data        = data_q;
    assign busy             = busy_q;
    assign frame_done       = done_q;
    assign bus_error        = err_q;

endmodule
